// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
// Arbitration mode encodings plus a one-hot to binary index encoder.
package mux_pkg;

  localparam logic [1:0] MUX_MODE_RR    = 2'd0;
  localparam logic [1:0] MUX_MODE_FIXED = 2'd1;
  localparam logic [1:0] MUX_MODE_SEL   = 2'd2;

  // Widest grant vector the encoder accepts; callers zero-extend into it.
  localparam int MUX_MAX_N = 32;

  // For a one-hot input, OR-ing the indices of the set bits yields the index.
  function automatic int onehot_to_index(input logic [MUX_MAX_N-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MUX_MAX_N; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, fixed lowest-index,
// or direct select (ptr carries the selected channel in select mode).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic [1:0]      mode,
  output logic [N-1:0]    grant
);

  logic found;
  int   idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/loops can leave a value unassigned and infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    case (mode)
      MUX_MODE_RR: begin
        for (int k = 0; k < N; k++) begin
          idx = int'(ptr) + k;
          if (idx >= N) idx = idx - N;
          if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
          end
        end
      end
      MUX_MODE_FIXED: begin
        for (int i = 0; i < N; i++) begin
          if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
      MUX_MODE_SEL: begin
        // Out-of-range selects grant nothing.
        if (int'(ptr) < N) begin
          if (req[ptr]) grant[ptr] = 1'b1;
        end
      end
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with selectable arbitration and one
// registered output stage tagging each word with its source channel.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [1:0] MODE_L = 2'(MODE);

  logic [SELW-1:0]      ptr;
  logic [SELW-1:0]      arb_ptr;
  logic [N-1:0]         grant;
  logic [MUX_MAX_N-1:0] grant_ext;
  logic [SELW-1:0]      g;
  logic                 load;
  logic                 any_grant;

  assign arb_ptr = (MODE_L == MUX_MODE_SEL) ? sel : ptr;

  rr_arbiter #(.N(N)) u_arb (
    .req   (in_valid),
    .ptr   (arb_ptr),
    .mode  (MODE_L),
    .grant (grant)
  );

  always_comb begin
    grant_ext          = '0;
    grant_ext[N-1:0]   = grant;
  end

  assign g         = SELW'(onehot_to_index(grant_ext));
  assign any_grant = |grant;
  assign load      = !out_valid || out_ready;
  assign in_ready  = rst ? '0 : (grant & {N{load}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any_grant;
      if (any_grant) begin
        out_data <= in_data[g*WIDTH +: WIDTH];
        out_chan <= g;
        // Pointer moves just past the served channel so it goes last next time.
        if (MODE_L == MUX_MODE_RR) begin
          ptr <= (g == SELW'(N - 1)) ? '0 : SELW'(g + 1'b1);
        end
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input, WIDTH-bit stream multiplexer with per-channel valid/ready handshakes, a selectable arbitration mode and one registered output stage. It is the sequential successor of the team's combinational 4-way 16-bit mux. It merges several producer streams onto one consumer bus, tags each word with its source channel, and sustains one word per cycle.

## Interface
- `WIDTH`, default 16: data width per channel.
- `N`, default 4: number of input channels, N ≥ 2. Need not be a power of two.
- `MODE`, default 0: arbitration mode.
  - 0: round-robin.
  - 1: fixed priority, lowest index wins.
  - 2: external select via `sel`.
- `SELW`, derived localparam, not overridable: `$clog2(N)`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_data`  in  N*WIDTH  — channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  — per-channel valid.
- `in_ready`  out  N  — per-channel ready; at most one bit high.
- `sel`  in  SELW  — channel select; used only in MODE 2.
- `out_data`  out  WIDTH  — registered output word.
- `out_chan`  out  SELW  — source channel of `out_data`.
- `out_valid`  out  1  — output word valid.
- `out_ready`  in  1  — consumer ready.

## Operation
- **Transfer rule:** a transfer occurs on any interface when valid and ready are both high at a rising edge.
  - Producers hold data stable while valid is high and ready is low.
  - Producers must not drop valid before the transfer completes.
- **Load enable:** `load = !out_valid || out_ready`. The output register can accept a word when it is empty or being drained in the same cycle.
- **Grant:** a one-hot vector is computed combinationally from `in_valid` and the mode. `in_ready[i] = grant[i] & load`.
- **MODE 0:**
  - Search starts at pointer `ptr` and proceeds ascending with wrap (ptr, ptr+1, …, N-1, 0, …).
  - The first valid channel wins.
  - On each accepted transfer from channel g, `ptr <= (g == N-1) ? 0 : g+1`.
  - `ptr` is unchanged when nothing is accepted.
- **MODE 1:** the lowest-index valid channel wins. `ptr` is unused.
- **MODE 2:**
  - Grant goes to channel `sel` only when `in_valid[sel]` is high.
  - `sel ≥ N` grants nothing.
  - `sel` may change on any cycle.
- **On acceptance:** `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- **Load with no grant:** `out_valid <= 0`.
- **Output held:** while `out_valid && !out_ready`, `out_data`, `out_chan` and `out_valid` hold, and all `in_ready` bits are low.
- **No combinational path** from `out_data`/`out_chan` to any input. The only paths to `in_ready` are from `out_valid`, `out_ready`, `in_valid`, `sel` and `ptr`.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`.
  - During `rst`, all `in_ready` bits read 0.
- **Reset mid-operation:** a held output word is discarded. No input transfer is counted in the reset cycle.
- **Latency:** 1 cycle from input transfer to `out_valid`.
- **Throughput:** one word per cycle when `out_ready` is held high.
- **No valid inputs:** `out_valid` falls on the edge after the last word drains.
- **Simultaneous drain and load:** the new word replaces the old one on the same edge, with no bubble.
- **Backpressure:** `out_ready` low with `out_valid` high stalls all inputs. No word is lost or duplicated.
- **`out_ready` high while `out_valid` low:** ignored.
- **Non-power-of-two N:** `ptr` and `out_chan` never take values ≥ N.

## Structure
- **Shared package `mux_pkg`:**
  - Mode constants `MUX_MODE_RR=0`, `MUX_MODE_FIXED=1`, `MUX_MODE_SEL=2`.
  - A function returning the one-hot-to-index encoding.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`, `mode`.
  - Output: `grant[N]` (one-hot, combinational).
  - Instantiated once.
- **Top level:** the output register, `ptr` update and `in_ready` gating stay in `stream_mux_rr`.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `in_valid=1111`.
  - → `out_valid=0`, `out_data=0`, `in_ready=0000` throughout.
  - → first word after release comes from channel 0.
- **MODE 0, N=4, WIDTH=16, all valid, `out_ready=1`:**
  - `in_data` = 0x0A00, 0x0B11, 0x0C22, 0x0D33.
  - → outputs 0x0A00, 0x0B11, 0x0C22, 0x0D33, 0x0A00… with `out_chan` 0,1,2,3,0, one per cycle, starting 1 cycle after reset release.
- **Backpressure:** channel 2 sends 0x1234, then `out_ready=0` for 3 cycles.
  - → `out_data=0x1234`, `out_chan=2`, `out_valid=1` held.
  - → `in_ready=0000`.
  - → on release, the next word follows with no bubble.
- **MODE 1, valid=1010:**
  - → channel 1 is always granted.
  - → channel 3 starves until `in_valid[1]` drops, then is granted next cycle.
- **MODE 2, N=3:**
  - `sel=2` with `in_valid=100` → `out_chan=2`.
  - `sel=3` → no grant; `out_valid` falls after drain.
  - `sel=0` with `in_valid[0]=0` → no grant.
- **Mid-stream reset:** assert `rst` while `out_valid=1`, `out_ready=0`.
  - → `out_valid=0` next edge.
  - → `ptr` returns to 0, so channel 0 wins next even if channel 3 was last served.
